uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Message-level round-robin arbiter that shares one UART transmit path (TX FIFO write port: wr_uart / w_data / tx_full) among NREQ requesters.
- A requester, once granted, owns the TX FIFO until it finishes a multi-byte message (last byte flagged), drops its request, or hits the MAX_LEN fairness limit.
- Sits between the client blocks and the uart top-level write interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 2, index width, clog2(NREQ).
- D_BIT, 8, data bits per byte; matches the uart D_BIT.
- MAX_LEN, 16, maximum bytes per grant before forced release (≥1).
- LEN_W, 5, counter width, able to hold MAX_LEN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; byte valid while high.
- last  input  NREQ  per-requester flag: current byte ends the message.
- data  input  NREQ*D_BIT  requester i byte at data[i*D_BIT +: D_BIT].
- tx_full  input  1  TX FIFO full, from uart.
- grant  output  NREQ  registered one-hot owner; all zero when idle.
- ack  output  NREQ  byte accepted from requester i this cycle.
- wr_uart  output  1  TX FIFO write strobe, to uart.
- w_data  output  D_BIT  byte to TX FIFO, to uart.
- busy  output  1  high in SEND state.
- trunc  output  1  one-cycle pulse when a grant is forcibly released at MAX_LEN.

Behaviour:
- Reset (synchronous, on clk rising edge with rst=1):
  - state=IDLE, grant=0, ptr=NREQ-1, cnt=0, trunc=0.
  - wr_uart=0, ack=0, busy=0, w_data=0.
  - Reset overrides everything, including mid-message; a partial message is abandoned, with no further writes.
- States: IDLE, SEND.
- IDLE:
  - grant=0, no transfers.
  - If any req bit is high, pick the first set index searching ptr+1, ptr+2, … modulo NREQ.
  - Next cycle: grant is one-hot on the winner, state=SEND, cnt=0.
  - With req=0, stay in IDLE.
- SEND (owner g):
  - Transfer condition xfer = req[g] & ~tx_full.
  - wr_uart, ack[g] and w_data are combinational in the same cycle:
    - wr_uart = xfer.
    - ack[g] = xfer.
    - w_data = data slice g when xfer, else 0.
  - ack bits of non-owners are always 0.
  - On xfer: cnt increments.
  - Release on xfer & last[g]: next state IDLE, ptr<=g.
  - Release on xfer & cnt==MAX_LEN-1 & ~last[g]: next state IDLE, ptr<=g, trunc pulses 1 the following cycle.
  - Release on ~req[g] (abort): next state IDLE, ptr<=g, no write that cycle.
  - tx_full=1 with req[g]=1: stall, hold state, no write, cnt unchanged. There is no stall timeout.
- Latency and gaps:
  - req rising in IDLE at cycle N: grant at N+1; first write at N+1 if tx_full=0.
  - Every release costs exactly one IDLE cycle before the next grant (one-cycle gap minimum).
  - Back-to-back messages from the same requester are allowed, subject to the round-robin order.
- Requester rule: data[i] and last[i] must be stable while req[i]=1 and ack[i]=0. The requester advances on ack[i].
- busy = (state==SEND).
- Fairness: with all requests held continuously, grants rotate 0,1,2,3,0,…

Test Plan:
- Single message: reset, then req[2]=1 with bytes 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant=0100 one cycle later; wr_uart high 3 consecutive cycles with w_data 0x41,0x42,0x43; ack[2] on each; grant=0 next cycle; busy low.
- Round robin: req=1111, each sending a 1-byte message with last=1 -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle between grants; w_data matches each owner's byte.
- Backpressure: owner 0 mid-message, tx_full=1 for 5 cycles -> wr_uart=0 and ack=0 for 5 cycles, grant held, cnt frozen; writes resume the cycle tx_full falls, with no byte lost or duplicated.
- Truncation: MAX_LEN=16, requester 1 streams 20 bytes without last -> exactly 16 writes, trunc pulses once, grant drops; requester 1 re-granted only after other pending requesters are served.
- Abort: owner 3 drops req after 2 of 4 bytes -> no further wr_uart, grant=0 next cycle, ptr=3, so a pending req[0] is granted next.
- Reset mid-operation: rst=1 during the 2nd byte of a message -> next cycle grant=0, wr_uart=0, busy=0; after rst falls with req=0001, grant=0001 (ptr reset to NREQ-1).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART TX FIFO write port among NREQ requesters.
// An owner keeps the grant until its last byte, an abort, or the MAX_LEN fairness cut-off.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned D_BIT   = 8,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    input  logic [NREQ*D_BIT-1:0]   data,
    input  logic                    tx_full,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic                    wr_uart,
    output logic [D_BIT-1:0]        w_data,
    output logic                    busy,
    output logic                    trunc
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              trunc_q, trunc_d;

    logic              found;
    logic [IDX_W-1:0]  win;
    logic              xfer;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = idx[IDX_W-1:0];
            end
        end
    end

    // Writes are suppressed while reset is asserted so an abandoned message emits nothing more.
    assign xfer = (state_q == StSend) && req[owner_q] && !tx_full && !rst;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StSend;
                    grant_d = NREQ'(1) << win;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            StSend: begin
                if (!req[owner_q]) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (last[owner_q]) begin
                        state_d = StIdle;
                        grant_d = '0;
                        ptr_d   = owner_q;
                    end else if (cnt_q == LEN_W'(MAX_LEN - 1)) begin
                        state_d = StIdle;
                        grant_d = '0;
                        ptr_d   = owner_q;
                        trunc_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant   = grant_q;
    assign ack     = xfer ? grant_q : '0;
    assign wr_uart = xfer;
    assign w_data  = xfer ? data[32'(owner_q)*D_BIT +: D_BIT] : '0;
    assign busy    = (state_q == StSend);
    assign trunc   = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: single message, round robin, backpressure,
// truncation, abort and mid-message reset.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic        tx_full;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic        trunc;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .data    (data),
        .tx_full (tx_full),
        .grant   (grant),
        .ack     (ack),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .busy    (busy),
        .trunc   (trunc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        data[i*8 +: 8] = b;
    endtask

    // Apply inputs for one cycle, check combinational and registered outputs, advance a cycle.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic f, input logic [3:0] eg, input logic [3:0] ea,
                        input logic ew, input logic [7:0] ed, input logic eb);
        req = r;
        last = l;
        tx_full = f;
        #1;
        check_eq({tag, " grant"}, 32'(grant), 32'(eg));
        check_eq({tag, " ack"}, 32'(ack), 32'(ea));
        check_eq({tag, " wr_uart"}, 32'(wr_uart), 32'(ew));
        check_eq({tag, " w_data"}, 32'(w_data), 32'(ed));
        check_eq({tag, " busy"}, 32'(busy), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        last = '0;
        tx_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        data = '0;
        do_reset();

        // Reset state
        check_eq("rst trunc", 32'(trunc), 32'd0);
        step("rst", 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

        // Single three-byte message from requester 2
        set_byte(2, 8'h41);
        step("s0", 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("s1", 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'h41, 1);
        set_byte(2, 8'h42);
        step("s2", 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'h42, 1);
        set_byte(2, 8'h43);
        step("s3", 4'b0100, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'h43, 1);
        step("s4", 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

        // Round robin with one-byte messages
        do_reset();
        for (int i = 0; i < 4; i++) set_byte(i, 8'hA0 + 8'(i));
        step("rr0", 4'b1111, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            step($sformatf("rr%0d g", k), 4'b1111, 4'b1111, 0, oh, oh, 1, 8'hA0 + 8'(k % 4), 1);
            step($sformatf("rr%0d i", k), (k == 4) ? 4'b0000 : 4'b1111, 4'b1111, 0,
                 4'b0000, 4'b0000, 0, 8'h00, 0);
        end

        // Backpressure on owner 0
        do_reset();
        set_byte(0, 8'h10);
        step("bp0", 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("bp1", 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'h10, 1);
        set_byte(0, 8'h11);
        for (int k = 0; k < 5; k++)
            step($sformatf("bp stall%0d", k), 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 0, 8'h00, 1);
        step("bp2", 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'h11, 1);
        set_byte(0, 8'h12);
        step("bp3", 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'h12, 1);
        step("bp4", 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

        // Truncation: requester 1 streams without last, others join later
        do_reset();
        set_byte(0, 8'hC0);
        set_byte(2, 8'hC2);
        set_byte(1, 8'h50);
        step("tr0", 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        for (int k = 0; k < 16; k++) begin
            set_byte(1, 8'h50 + 8'(k));
            step($sformatf("tr w%0d", k), 4'b0111, 4'b0101, 0, 4'b0010, 4'b0010, 1,
                 8'h50 + 8'(k), 1);
            if (k == 15) check_eq("tr pulse", 32'(trunc), 32'd1);
            else check_eq($sformatf("tr quiet%0d", k), 32'(trunc), 32'd0);
        end
        set_byte(1, 8'h60);
        step("tr i1", 4'b0111, 4'b0101, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        check_eq("tr pulse end", 32'(trunc), 32'd0);
        step("tr g2", 4'b0111, 4'b0101, 0, 4'b0100, 4'b0100, 1, 8'hC2, 1);
        step("tr i2", 4'b0011, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("tr g0", 4'b0011, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hC0, 1);
        step("tr i3", 4'b0010, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("tr g1", 4'b0010, 4'b0000, 0, 4'b0010, 4'b0010, 1, 8'h60, 1);

        // Abort: owner 3 drops req after 2 of 4 bytes, pending req[0] served next
        do_reset();
        set_byte(3, 8'hD0);
        set_byte(0, 8'hE0);
        step("ab0", 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("ab1", 4'b1001, 4'b0001, 0, 4'b1000, 4'b1000, 1, 8'hD0, 1);
        set_byte(3, 8'hD1);
        step("ab2", 4'b1001, 4'b0001, 0, 4'b1000, 4'b1000, 1, 8'hD1, 1);
        step("ab3", 4'b0001, 4'b0001, 0, 4'b1000, 4'b0000, 0, 8'h00, 1);
        step("ab4", 4'b0001, 4'b0001, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("ab5", 4'b0001, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hE0, 1);
        step("ab6", 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

        // Reset during the second byte of a message; ptr returns to NREQ-1
        set_byte(2, 8'h71);
        step("rm0", 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("rm1", 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'h71, 1);
        set_byte(2, 8'h72);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rm2", 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
        step("rm3", 4'b0011, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hE0, 1);
        step("rm4", 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
